// File: rtl/seg_pkg.sv
// Shared seven-segment constants: active-low {g,f,e,d,c,b,a} digit patterns,
// the BLANK code and the BLANK/DASH patterns used by the scan driver and decoder.
// No ports: package only.
package seg_pkg;

    typedef logic [6:0] seg_t;

    // Digit code that renders as an unlit digit.
    localparam logic [3:0] BLANK = 4'hA;

    localparam seg_t SEG_0     = 7'h40;
    localparam seg_t SEG_1     = 7'h79;
    localparam seg_t SEG_2     = 7'h24;
    localparam seg_t SEG_3     = 7'h30;
    localparam seg_t SEG_4     = 7'h19;
    localparam seg_t SEG_5     = 7'h12;
    localparam seg_t SEG_6     = 7'h02;
    localparam seg_t SEG_7     = 7'h78;
    localparam seg_t SEG_8     = 7'h00;
    localparam seg_t SEG_9     = 7'h10;
    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_DASH  = 7'h3F;  // g segment only

endpackage

// File: rtl/seven_seg_scan_if.sv
// Display bundle between the timer side and the multiplexed 4-digit display.
// Signals: nums (4 digit codes, [15:12] leftmost), an (active-low anodes,
// an[3] leftmost), seg (active-low {g,f,e,d,c,b,a}), dp (active-low point).
interface seven_seg_scan_if;
    logic [15:0] nums;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    // master: the timer/test side that supplies digits and watches the display
    modport master (output nums, input an, seg, dp);
    // slave: the scan driver
    modport slave  (input nums, output an, seg, dp);
endinterface

// File: rtl/bcd_to_seg.sv
// Purpose: combinational 4-bit digit code to active-low segment pattern.
// Latency: none (pure combinational). Backpressure: none, always valid.
// Ports: code_i (0-9 digit, 0xA blank, 0xB-0xF dash), seg_o ({g,f,e,d,c,b,a}).
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] code_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (code_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            BLANK:   seg_o = SEG_BLANK;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Purpose: time-multiplexed 4-digit seven-segment scan driver with anti-ghost gap.
// Latency: outputs registered, one cycle behind the (idx,cnt) scan state.
// Backpressure: none; nums is sampled once per frame and need not be held.
// Ports: clk, rst (sync, active-high), bus (slave modport: nums in; an/seg/dp out).
// Option: define LEADING_ZERO_BLANK_EN to blank the leftmost digit when it is 0.
module seven_seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV   = 100000,  // clk cycles per digit slot
    parameter int GAP_CYCLES = 1000     // blanked cycles at the start of each slot
) (
    input  logic             clk,
    input  logic             rst,
    seven_seg_scan_if.slave  bus
);

    localparam int                CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  GAP_V   = CNT_W'(GAP_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      snap_q, snap_d;
    logic             first_q;          // first cycle after reset release
    logic [3:0]       an_q, an_d;
    seg_t             seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             slot_end;
    logic [3:0]       code_raw;
    logic [3:0]       code;
    seg_t             dec_seg;

    bcd_to_seg u_dec (
        .code_i (code),
        .seg_o  (dec_seg)
    );

    always_comb begin
        slot_end = (cnt_q == CNT_MAX);
        cnt_d    = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d    = slot_end ? idx_q + 2'd1 : idx_q;

        // A new frame snapshot is taken either right after reset or on the
        // edge that takes idx 3->0, so the next four slots share one value.
        snap_d = (first_q || (slot_end && (idx_q == 2'd3))) ? bus.nums : snap_q;

        code_raw = snap_q[{idx_q, 2'b00} +: 4];
        code     = code_raw;
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx_q == 2'd3) && (code_raw == 4'd0)) begin
            code = BLANK;
        end
`endif

        an_d  = (cnt_q < GAP_V) ? 4'b1111 : ~(4'b0001 << idx_q);
        seg_d = dec_seg;
        // Decimal point after the minutes-ones digit acts as the min:sec colon.
        dp_d  = ~((idx_q == 2'd2) && (code_raw != BLANK));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            snap_q  <= 16'hAAAA;
            first_q <= 1'b1;
            an_q    <= 4'b1111;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            first_q <= 1'b0;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Purpose: self-checking bench for seven_seg_scan (SCAN_DIV=8, GAP_CYCLES=2).
// Latency: outputs compared #1 after each rising edge against a frame-level model.
// Backpressure: n/a. Honours LEADING_ZERO_BLANK_EN when defined for the build.
module tb_seven_seg_scan;

    localparam int SD  = 8;
    localparam int GAP = 2;
    localparam int FRAME = 4 * SD;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] Z3 = 7'h7F;
`else
    localparam logic [6:0] Z3 = 7'h40;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seven_seg_scan_if bus ();

    seven_seg_scan #(.SCAN_DIV(SD), .GAP_CYCLES(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    // nums value present during each post-reset state k (index = k)
    logic [15:0] hist[$];

    typedef struct {
        logic [15:0]       nums;
        logic [3:0][6:0]   segs;   // expected seg per idx, [0] = rightmost
        logic              dp2;    // expected dp on idx 2
    } vec_t;

    vec_t vecs[5];

    function automatic logic [6:0] pat(input logic [3:0] c);
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h7F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        return tbl[c];
    endfunction

    // Expected outputs visible after the edge that ends post-reset state k.
    function automatic void model(input int k, output logic [3:0] an_e,
                                  output logic [6:0] seg_e, output logic dp_e);
        int cnt, idx, fr;
        logic [15:0] snap;
        logic [3:0]  dig;
        logic [3:0]  shown;
        cnt = k % SD;
        idx = (k / SD) % 4;
        fr  = k / FRAME;
        if (k == 0)       snap = 16'hAAAA;
        else if (fr == 0) snap = hist[0];
        else              snap = hist[FRAME * fr - 1];
        dig   = snap[4*idx +: 4];
        shown = dig;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 3 && dig == 4'd0) shown = 4'hA;
`endif
        an_e  = (cnt < GAP) ? 4'b1111 : ~(4'b0001 << idx);
        seg_e = pat(shown);
        dp_e  = !(idx == 2 && dig != 4'hA);
    endfunction

    task automatic check(input string name, input logic [3:0] an_e,
                         input logic [6:0] seg_e, input logic dp_e);
        checks++;
        if (bus.an !== an_e || bus.seg !== seg_e || bus.dp !== dp_e) begin
            errors++;
            $display("FAIL %s k=%0d: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                     name, hist.size() - 1, bus.an, bus.seg, bus.dp, an_e, seg_e, dp_e);
        end
    endtask

    task automatic step();
        logic [3:0] a;
        logic [6:0] s;
        logic       d;
        hist.push_back(bus.nums);
        @(posedge clk); #1;
        model(hist.size() - 1, a, s, d);
        check("model", a, s, d);
    endtask

    task automatic pulse_reset(input string name);
        rst = 1'b1;
        @(posedge clk); #1;
        check(name, 4'b1111, 7'h7F, 1'b1);
        rst = 1'b0;
        hist.delete();
    endtask

    initial begin
        vecs[0] = '{16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b0};
        vecs[1] = '{16'hAAAA, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 1'b1};
        vecs[2] = '{16'h0F59, {Z3,    7'h3F, 7'h12, 7'h10}, 1'b0};
        vecs[3] = '{16'h0507, {Z3,    7'h12, 7'h40, 7'h78}, 1'b0};
        vecs[4] = '{16'h0012, {Z3,    7'h40, 7'h79, 7'h24}, 1'b0};

        rst = 1'b1;
        bus.nums = 16'h1234;
        @(posedge clk); #1;
        pulse_reset("reset");

        // Table: one frame per vector, checking the last cycle of each slot.
        for (int v = 0; v < 5; v++) begin
            bus.nums = vecs[v].nums;
            pulse_reset("reset_vec");
            for (int k = 0; k < FRAME + 2; k++) begin
                step();
                if (k < FRAME && (k % SD) == SD - 1)
                    check("table", ~(4'b0001 << (k / SD)), vecs[v].segs[k / SD],
                          (k / SD == 2) ? vecs[v].dp2 : 1'b1);
            end
        end

        // Slot-start gap timing, then reset mid-slot at idx=2, cnt=5.
        bus.nums = 16'h1234;
        pulse_reset("reset_gap");
        for (int k = 0; k < 2 * SD + 5; k++) begin
            step();
            if (k == 7)  check("gap_pre",   4'b1110, 7'h19, 1'b1);
            if (k == 8)  check("gap_0",     4'b1111, 7'h30, 1'b1);
            if (k == 9)  check("gap_1",     4'b1111, 7'h30, 1'b1);
            if (k == 10) check("gap_end",   4'b1101, 7'h30, 1'b1);
        end
        pulse_reset("rst_mid");
        for (int k = 0; k < SD; k++) begin
            step();
            if (k == 0) check("restart_0", 4'b1111, 7'h7F, 1'b1);
            if (k == 2) check("restart_2", 4'b1110, 7'h19, 1'b1);
        end

        // nums changes during idx=1; display holds old frame until the boundary.
        bus.nums = 16'h0012;
        pulse_reset("reset_hold");
        for (int k = 0; k < 3 * FRAME; k++) begin
            if (k == FRAME + SD + 3) bus.nums = 16'h0013;
            step();
            if (k == FRAME + 7)          check("hold_idx0", 4'b1110, 7'h24, 1'b1);
            if (k == FRAME + SD + 7)     check("hold_idx1", 4'b1101, 7'h79, 1'b1);
            if (k == 2 * FRAME + 7)      check("new_idx0",  4'b1110, 7'h30, 1'b1);
        end

        // Random digits and update times, with occasional mid-frame resets.
        bus.nums = 16'($urandom);
        pulse_reset("reset_rand");
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 19) == 0) bus.nums = 16'($urandom);
            if ($urandom_range(0, 299) == 0) pulse_reset("rst_rand");
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk cycles per digit slot (1 ms at 100 MHz); legal range 4..2^20.
REQ-002 SHALL have parameter GAP_CYCLES, default 1000, anti-ghost blank cycles at the start of each slot; legal range 0..SCAN_DIV-1.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port nums  input  16  four 4-bit digit codes from the timer: [15:12] min tens, [11:8] min ones, [7:4] sec tens, [3:0] sec ones.
REQ-006 SHALL have port an  output  4  digit anode enables, active-low; an[3] is the leftmost digit, nums[15:12].
REQ-007 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-008 SHALL have port dp  output  1  decimal point, active-low; used as the min:sec separator.

Function
REQ-009 SHALL keep slot counter cnt in 0..SCAN_DIV-1; it increments every cycle and wraps to 0 after SCAN_DIV-1.
REQ-010 SHALL keep digit index idx in 0..3; idx advances 0->1->2->3->0 on the cycle where cnt wraps.
REQ-011 SHALL keep a frame register snap, loaded from nums on the cycle idx goes 3->0, so a frame never mixes two nums values.
REQ-012 SHALL decode codes 0-9 to standard digit patterns, 0xA to blank (seg=7'h7F), and 0xB-0xF to a dash (g only, seg=7'h3F).
REQ-013 SHALL, for cnt<GAP_CYCLES, drive an=4'b1111; otherwise an has bit idx low and the others high.
REQ-014 SHALL drive seg with the decode of snap digit idx, and dp=0 only when idx==2 and that digit is not code 0xA; otherwise dp=1.
REQ-015 SHALL register an, seg and dp, giving a one-cycle latency from the (idx,cnt) state to the outputs.
REQ-016 SHALL not require nums to be held; values between frame boundaries are ignored.

Reset
REQ-017 SHALL, while rst=1, force cnt=0, idx=0, snap=16'hAAAA, an=4'b1111, seg=7'h7F and dp=1.
REQ-018 SHALL, when rst is asserted mid-slot or mid-frame, discard the partial slot and the frame; the first cycle after release starts slot 0 of a new frame.
REQ-019 SHALL load snap from nums on the first cycle after rst deasserts.

Configuration
REQ-020 SHALL, with LEADING_ZERO_BLANK_EN defined, blank digit 3 when snap[15:12]==0 and show all other digits normally.
REQ-021 SHALL, without LEADING_ZERO_BLANK_EN defined, display digit 3 per REQ-012 with no suppression.

Structure
REQ-022 SHALL place segment pattern constants, the BLANK code 4'hA and the DASH pattern in shared package seg_pkg.
REQ-023 SHALL implement decoding in a combinational sub-module bcd_to_seg (4-bit code in, 7-bit active-low pattern out), instantiated once.

Verification
REQ-024 SHALL cover: SCAN_DIV=8, GAP_CYCLES=2, nums=16'h1234 after reset -> an cycles 1110,1101,1011,0111 every 8 clk; seg=4,3,2,1 patterns (7'h19,7'h30,7'h24,7'h79); dp=0 only with an=1011.
REQ-025 SHALL cover: slot start -> an=1111 for exactly 2 cycles, then the digit enables 1 cycle after the registered state.
REQ-026 SHALL cover: nums=16'hAAAA -> seg=7'h7F and dp=1 on all slots; nums=16'h0F59 -> digit 2 shows the dash 7'h3F.
REQ-027 SHALL cover: nums changes 16'h0012->16'h0013 during idx=1 -> outputs keep 0012 until the next idx 3->0 boundary.
REQ-028 SHALL cover: rst pulsed during idx=2, cnt=5 -> the next cycle shows an=1111, seg=7'h7F, dp=1, and scanning restarts at idx=0, cnt=0.
REQ-029 SHALL cover: nums=16'h0507 with LEADING_ZERO_BLANK_EN defined -> digit 3 blank; without it -> digit 3 shows 7'h40.
